// File: rtl/alu_issue_ctrl.sv
// Decodes one RV32 ALU/branch op, drives a registered external ALU, and returns its result.
// Accept edge N loads the ALU drive; edge N+1 captures the result (DONE); in_ready follows out_ready in DONE.
module alu_issue_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_s,
    input  logic [31:0] alu_f,
    input  logic        alu_zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        zero,
    output logic        branch_taken,
    output logic        illegal
);

    localparam logic [3:0] S_ADD  = 4'b0000;
    localparam logic [3:0] S_SUB  = 4'b0001;
    localparam logic [3:0] S_SLL  = 4'b0010;
    localparam logic [3:0] S_SLT  = 4'b0011;
    localparam logic [3:0] S_XOR  = 4'b0100;
    localparam logic [3:0] S_SRL  = 4'b0101;
    localparam logic [3:0] S_OR   = 4'b0110;
    localparam logic [3:0] S_AND  = 4'b0111;
    localparam logic [3:0] S_SLTU = 4'b1000;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_B = 7'b1100011;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    typedef enum logic [2:0] {BR_NONE, BR_EQ, BR_NE, BR_LTU, BR_GEU} br_t;

    typedef struct packed {
        logic [31:0] b;
        logic [3:0]  s;
        br_t         br;
        logic        ill;
    } dec_t;

    state_t      state_q;
    logic [31:0] alu_a_q, alu_b_q;
    logic [3:0]  alu_s_q;
    br_t         br_q;
    logic        ill_pend_q;
    logic        out_valid_q;
    logic [31:0] result_q;
    logic        zero_q, branch_taken_q, illegal_q;

    dec_t        dec_d;
    logic        accept;
    logic        taken_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        unused_instr_fields;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign unused_instr_fields = ^{instr[19:15], instr[11:7]};

    always_comb begin
        dec_d     = '0;
        dec_d.br  = BR_NONE;
        dec_d.ill = 1'b1;
        case (opcode)
            OP_R: begin
                dec_d.b = rs2_val;
                if (funct7 == 7'b0000000) begin
                    dec_d.ill = 1'b0;
                    case (funct3)
                        3'b000:  dec_d.s = S_ADD;
                        3'b001:  dec_d.s = S_SLL;
                        3'b010:  dec_d.s = S_SLT;
                        3'b011:  dec_d.s = S_SLTU;
                        3'b100:  dec_d.s = S_XOR;
                        3'b101:  dec_d.s = S_SRL;
                        3'b110:  dec_d.s = S_OR;
                        default: dec_d.s = S_AND;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec_d.ill = 1'b0;
                    dec_d.s   = S_SUB;
                end
            end
            OP_I: begin
                dec_d.b   = {{20{instr[31]}}, instr[31:20]};
                dec_d.ill = 1'b0;
                case (funct3)
                    3'b000:  dec_d.s = S_ADD;
                    3'b010:  dec_d.s = S_SLT;
                    3'b011:  dec_d.s = S_SLTU;
                    3'b100:  dec_d.s = S_XOR;
                    3'b110:  dec_d.s = S_OR;
                    3'b111:  dec_d.s = S_AND;
                    3'b001: begin
                        dec_d.s   = S_SLL;
                        dec_d.b   = {27'd0, instr[24:20]};
                        dec_d.ill = (funct7 != 7'b0000000);
                    end
                    default: begin
                        // funct3 101: only SRLI is supported; SRAI falls out as illegal
                        dec_d.s   = S_SRL;
                        dec_d.b   = {27'd0, instr[24:20]};
                        dec_d.ill = (funct7 != 7'b0000000);
                    end
                endcase
            end
            OP_B: begin
                dec_d.b = rs2_val;
                case (funct3)
                    3'b000: begin dec_d.s = S_SUB;  dec_d.br = BR_EQ;  dec_d.ill = 1'b0; end
                    3'b001: begin dec_d.s = S_SUB;  dec_d.br = BR_NE;  dec_d.ill = 1'b0; end
                    3'b110: begin dec_d.s = S_SLTU; dec_d.br = BR_LTU; dec_d.ill = 1'b0; end
                    3'b111: begin dec_d.s = S_SLTU; dec_d.br = BR_GEU; dec_d.ill = 1'b0; end
                    default: ;
                endcase
            end
            default: ;
        endcase
        if (dec_d.ill) begin
            dec_d.b  = '0;
            dec_d.s  = '0;
            dec_d.br = BR_NONE;
        end
    end

    always_comb begin
        case (br_q)
            BR_EQ:   taken_d = alu_zero;
            BR_NE:   taken_d = !alu_zero;
            BR_LTU:  taken_d = alu_f[0];
            BR_GEU:  taken_d = !alu_f[0];
            default: taken_d = 1'b0;
        endcase
    end

    always_comb begin
        case (state_q)
            IDLE:    in_ready = 1'b1;
            DONE:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_s_q        <= '0;
            br_q           <= BR_NONE;
            ill_pend_q     <= 1'b0;
            out_valid_q    <= 1'b0;
            result_q       <= '0;
            zero_q         <= 1'b0;
            branch_taken_q <= 1'b0;
            illegal_q      <= 1'b0;
        end else begin
            if (accept) begin
                alu_a_q    <= dec_d.ill ? 32'd0 : rs1_val;
                alu_b_q    <= dec_d.b;
                alu_s_q    <= dec_d.s;
                br_q       <= dec_d.br;
                ill_pend_q <= dec_d.ill;
            end
            case (state_q)
                IDLE: begin
                    if (accept) state_q <= EXEC;
                end
                EXEC: begin
                    // Illegal ops still spend a cycle here but report a zeroed result
                    result_q       <= ill_pend_q ? 32'd0 : alu_f;
                    zero_q         <= ill_pend_q ? 1'b0 : alu_zero;
                    branch_taken_q <= ill_pend_q ? 1'b0 : taken_d;
                    illegal_q      <= ill_pend_q;
                    out_valid_q    <= 1'b1;
                    state_q        <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= in_valid ? EXEC : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_s        = alu_s_q;
    assign out_valid    = out_valid_q;
    assign result       = result_q;
    assign zero         = zero_q;
    assign branch_taken = branch_taken_q;
    assign illegal      = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU closing the loop.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] instr, rs1_val, rs2_val;
    logic [31:0] alu_a, alu_b, alu_f;
    logic [3:0]  alu_s;
    logic        alu_zero;
    logic        out_valid, out_ready;
    logic [31:0] result;
    logic        zero, branch_taken, illegal;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] I_ADD  = 32'h0000_0033;
    localparam logic [31:0] I_XOR  = 32'h0000_4033;
    localparam logic [31:0] I_OR   = 32'h0000_6033;
    localparam logic [31:0] I_SRA  = 32'h4000_5033;
    localparam logic [31:0] I_ADDI = 32'hFFF0_0013;
    localparam logic [31:0] I_SLLI = 32'h0040_1013;
    localparam logic [31:0] I_BEQ  = 32'h0000_0063;
    localparam logic [31:0] I_BNE  = 32'h0000_1063;
    localparam logic [31:0] I_BLT  = 32'h0000_4063;
    localparam logic [31:0] I_BLTU = 32'h0000_6063;
    localparam logic [31:0] I_BGEU = 32'h0000_7063;

    always #5 clk = ~clk;

    always_comb begin
        case (alu_s)
            4'b0000: alu_f = alu_a + alu_b;
            4'b0001: alu_f = alu_a - alu_b;
            4'b0010: alu_f = alu_a << alu_b[4:0];
            4'b0011: alu_f = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'b0100: alu_f = alu_a ^ alu_b;
            4'b0101: alu_f = alu_a >> alu_b[4:0];
            4'b0110: alu_f = alu_a | alu_b;
            4'b0111: alu_f = alu_a & alu_b;
            4'b1000: alu_f = {31'd0, alu_a < alu_b};
            default: alu_f = 32'd0;
        endcase
    end
    assign alu_zero = (alu_f == 32'd0);

    alu_issue_ctrl dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
        .alu_f(alu_f), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .branch_taken(branch_taken), .illegal(illegal)
    );

    // Presents an op, waits (bounded) for acceptance, returns at the negedge after the accept edge.
    task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        @(negedge clk);
        instr = ins; rs1_val = a; rs2_val = b; in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        repeat (2) @(negedge clk);
        total++;
        if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_s !== 4'd0) begin
            bad++;
            $display("FAIL reset_alu: a=%h b=%h s=%b required 0", alu_a, alu_b, alu_s);
        end
        total++;
        if (result !== 32'd0 || zero !== 1'b0 || branch_taken !== 1'b0 || illegal !== 1'b0) begin
            bad++;
            $display("FAIL reset_out: result=%h zero=%b bt=%b ill=%b required 0", result, zero, branch_taken, illegal);
        end
        rst = 1'b0;
    endtask

    task automatic test_add();
        issue(I_ADD, 32'd5, 32'd7);
        total++;
        if (alu_s !== 4'b0000 || alu_a !== 32'd5 || alu_b !== 32'd7) begin
            bad++;
            $display("FAIL add_drive: s=%b a=%h b=%h required 0000/5/7", alu_s, alu_a, alu_b);
        end
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL add_exec: out_valid=%b in_ready=%b required 0/0", out_valid, in_ready);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || result !== 32'd12 || zero !== 1'b0) begin
            bad++;
            $display("FAIL add_done: out_valid=%b result=%h zero=%b required 1/0000000c/0", out_valid, result, zero);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || result !== 32'd12) begin
            bad++;
            $display("FAIL add_hold: out_valid=%b result=%h required 1/0000000c", out_valid, result);
        end
        release_result();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL add_idle: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_branch();
        logic [31:0] ins [4];
        logic [31:0] a   [4];
        logic [31:0] b   [4];
        logic [3:0]  s   [4];
        logic [31:0] f   [4];
        logic        bt  [4];
        ins = '{I_BEQ, I_BNE, I_BLTU, I_BGEU};
        a   = '{32'h1234, 32'h1234, 32'd3, 32'd3};
        b   = '{32'h1234, 32'h1234, 32'd5, 32'd5};
        s   = '{4'b0001, 4'b0001, 4'b1000, 4'b1000};
        f   = '{32'd0, 32'd0, 32'd1, 32'd1};
        bt  = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            issue(ins[i], a[i], b[i]);
            total++;
            if (alu_s !== s[i] || alu_b !== b[i]) begin
                bad++;
                $display("FAIL branch_drive[%0d]: s=%b b=%h required %b/%h", i, alu_s, alu_b, s[i], b[i]);
            end
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || result !== f[i] || branch_taken !== bt[i] || illegal !== 1'b0) begin
                bad++;
                $display("FAIL branch_done[%0d]: ov=%b result=%h bt=%b ill=%b required 1/%h/%b/0",
                         i, out_valid, result, branch_taken, illegal, f[i], bt[i]);
            end
            release_result();
        end
    endtask

    task automatic test_imm();
        issue(I_ADDI, 32'd1, 32'hDEAD_BEEF);
        total++;
        if (alu_b !== 32'hFFFF_FFFF || alu_s !== 4'b0000) begin
            bad++;
            $display("FAIL addi_drive: b=%h s=%b required ffffffff/0000", alu_b, alu_s);
        end
        @(negedge clk);
        total++;
        if (result !== 32'd0 || zero !== 1'b1 || branch_taken !== 1'b0) begin
            bad++;
            $display("FAIL addi_done: result=%h zero=%b bt=%b required 0/1/0", result, zero, branch_taken);
        end
        release_result();
        issue(I_SLLI, 32'd1, 32'hDEAD_BEEF);
        total++;
        if (alu_b !== 32'd4 || alu_s !== 4'b0010) begin
            bad++;
            $display("FAIL slli_drive: b=%h s=%b required 00000004/0010", alu_b, alu_s);
        end
        @(negedge clk);
        total++;
        if (result !== 32'd16 || zero !== 1'b0) begin
            bad++;
            $display("FAIL slli_done: result=%h zero=%b required 00000010/0", result, zero);
        end
        release_result();
    endtask

    task automatic test_illegal();
        logic [31:0] ins [2];
        ins = '{I_SRA, I_BLT};
        for (int i = 0; i < 2; i++) begin
            issue(ins[i], 32'h8000_0000, 32'd3);
            total++;
            if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_s !== 4'd0) begin
                bad++;
                $display("FAIL illegal_drive[%0d]: a=%h b=%h s=%b required 0", i, alu_a, alu_b, alu_s);
            end
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || illegal !== 1'b1 || result !== 32'd0 || zero !== 1'b0 || branch_taken !== 1'b0) begin
                bad++;
                $display("FAIL illegal_done[%0d]: ov=%b ill=%b result=%h zero=%b bt=%b required 1/1/0/0/0",
                         i, out_valid, illegal, result, zero, branch_taken);
            end
            release_result();
        end
    endtask

    task automatic test_back_to_back();
        issue(I_XOR, 32'hF0, 32'hFF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || result !== 32'h0F || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall[%0d]: ov=%b result=%h in_ready=%b required 1/0000000f/0",
                         i, out_valid, result, in_ready);
            end
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        instr = I_OR; rs1_val = 32'h10; rs2_val = 32'h01;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready: in_ready=%b required 1", in_ready);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || alu_s !== 4'b0110 || alu_a !== 32'h10) begin
            bad++;
            $display("FAIL b2b_exec: ov=%b in_ready=%b s=%b a=%h required 0/0/0110/10",
                     out_valid, in_ready, alu_s, alu_a);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || result !== 32'h11) begin
            bad++;
            $display("FAIL b2b_done: ov=%b result=%h required 1/00000011", out_valid, result);
        end
    endtask

    task automatic test_reset_mid();
        release_result();
        issue(I_ADD, 32'd5, 32'd7);
        rst = 1'b1;
        #1;
        total++;
        if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_s !== 4'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_drive: a=%h b=%h s=%b in_ready=%b ov=%b required 0/0/0/1/0",
                     alu_a, alu_b, alu_s, in_ready, out_valid);
        end
        total++;
        if (result !== 32'd0 || zero !== 1'b0 || branch_taken !== 1'b0 || illegal !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_out: result=%h zero=%b bt=%b ill=%b required 0", result, zero, branch_taken, illegal);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL rst_mid_quiet[%0d]: out_valid=%b required 0", i, out_valid);
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        instr = 32'd0; rs1_val = 32'd0; rs2_val = 32'd0;
        test_reset();
        test_add();
        test_branch();
        test_imm();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
